// File: rtl/pipe_delay_checker.sv
// rtl/pipe_delay_checker.sv - checks an upstream blocked/non-blocked demo stage against a 2-deep delay model of a
// Non-blocked pair must track (a_d1, a_d2); blocked pair must collapse to (a_d1, a_d1).
module pipe_delay_checker #(
    parameter int CNT_W       = 8,
    parameter int FILL        = 2,
    parameter int HALT_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             a,
    input  logic             b_blocked,
    input  logic             c_blocked,
    input  logic             b_non_blocked,
    input  logic             c_non_blocked,
    output logic             busy,
    output logic             done,
    output logic             err_blk,
    output logic             err_nb,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt
);

    localparam int FW = $clog2(FILL + 1);
    localparam logic [FW-1:0] FILL_LAST = FW'(FILL - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_CHECK = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          r_state;
    logic [FW-1:0]   r_fill_cnt;
    logic            r_a_d1;
    logic            r_a_d2;
    logic            w_mis_nb;
    logic            w_mis_blk;
    logic            w_mis;

    assign w_mis_nb  = (b_non_blocked != r_a_d1) | (c_non_blocked != r_a_d2);
    assign w_mis_blk = (b_blocked != r_a_d1) | (c_blocked != r_a_d1);
    assign w_mis     = w_mis_nb | w_mis_blk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_fill_cnt <= '0;
            r_a_d1     <= 1'b0;
            r_a_d2     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_blk    <= 1'b0;
            err_nb     <= 1'b0;
            err_cnt    <= '0;
            chk_cnt    <= '0;
        end else begin
            r_a_d1 <= a;
            r_a_d2 <= r_a_d1;
            done   <= 1'b0;
            // start restarts from any state and beats a simultaneous stop
            if (start) begin
                r_state    <= S_FILL;
                r_fill_cnt <= '0;
                busy       <= 1'b1;
                err_blk    <= 1'b0;
                err_nb     <= 1'b0;
                err_cnt    <= '0;
                chk_cnt    <= '0;
            end else begin
                case (r_state)
                    S_FILL: begin
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                        if (stop) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else if (r_fill_cnt == FILL_LAST) begin
                            r_state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (chk_cnt != CNT_MAX) chk_cnt <= chk_cnt + 1'b1;
                        if (w_mis_blk) err_blk <= 1'b1;
                        if (w_mis_nb) err_nb <= 1'b1;
                        if (w_mis && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + 1'b1;
                        // the terminating edge is still counted above
                        if (w_mis && (HALT_ON_ERR != 0)) begin
                            r_state <= S_HALT;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else if (stop) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_delay_checker.sv
// tb/tb_pipe_delay_checker.sv - table-driven and directed checks of pipe_delay_checker
module tb_pipe_delay_checker;

    localparam int FILL = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic a = 1'b0;
    logic fault_nb = 1'b0;
    logic fault_blk = 1'b0;
    logic inj = 1'b0;
    logic a_tog = 1'b0;

    logic ub_nb, uc_nb, ub_blk, uc_blk;
    logic b_blocked, c_blocked, b_non_blocked, c_non_blocked;

    logic       d_busy, d_done, d_err_blk, d_err_nb;
    logic [7:0] d_err_cnt, d_chk_cnt;
    logic       s_busy, s_done, s_err_blk, s_err_nb;
    logic [2:0] s_err_cnt, s_chk_cnt;
    logic       h_busy, h_done, h_err_blk, h_err_nb;
    logic [7:0] h_err_cnt, h_chk_cnt;

    int total = 0;
    int bad = 0;
    int n_done_d = 0;
    int n_done_h = 0;
    int pidx = 0;
    bit pat [10] = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1};

    always #5 clk = ~clk;

    // reference upstream stage: non-blocked is a 2-stage shift, blocked collapses to one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ub_nb  <= 1'b0;
            uc_nb  <= 1'b0;
            ub_blk <= 1'b0;
            uc_blk <= 1'b0;
        end else begin
            ub_nb  <= a;
            uc_nb  <= ub_nb;
            ub_blk <= a;
            uc_blk <= a;
        end
    end

    assign b_non_blocked = ub_nb;
    assign c_non_blocked = fault_nb ? ub_nb : uc_nb;
    assign b_blocked     = ub_blk ^ inj;
    assign c_blocked     = uc_blk ^ fault_blk;

    pipe_delay_checker #(.CNT_W(8), .FILL(FILL), .HALT_ON_ERR(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .a(a),
        .b_blocked(b_blocked), .c_blocked(c_blocked),
        .b_non_blocked(b_non_blocked), .c_non_blocked(c_non_blocked),
        .busy(d_busy), .done(d_done), .err_blk(d_err_blk), .err_nb(d_err_nb),
        .err_cnt(d_err_cnt), .chk_cnt(d_chk_cnt)
    );

    pipe_delay_checker #(.CNT_W(3), .FILL(FILL), .HALT_ON_ERR(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .a(a),
        .b_blocked(b_blocked), .c_blocked(c_blocked),
        .b_non_blocked(b_non_blocked), .c_non_blocked(c_non_blocked),
        .busy(s_busy), .done(s_done), .err_blk(s_err_blk), .err_nb(s_err_nb),
        .err_cnt(s_err_cnt), .chk_cnt(s_chk_cnt)
    );

    pipe_delay_checker #(.CNT_W(8), .FILL(FILL), .HALT_ON_ERR(1)) u_halt (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .a(a),
        .b_blocked(b_blocked), .c_blocked(c_blocked),
        .b_non_blocked(b_non_blocked), .c_non_blocked(c_non_blocked),
        .busy(h_busy), .done(h_done), .err_blk(h_err_blk), .err_nb(h_err_nb),
        .err_cnt(h_err_cnt), .chk_cnt(h_chk_cnt)
    );

    always @(negedge clk) begin
        if (d_done) n_done_d++;
        if (h_done) n_done_h++;
    end

    typedef struct {
        logic f_nb;
        logic f_blk;
        logic tog;
        int   n_chk;
        logic e_blk;
        logic e_nb;
        int   e_err;
        int   e_chk;
    } vec_t;

    vec_t tv [3];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (a_tog) a = ~a;
        else begin
            a = pat[pidx];
            pidx = (pidx == 9) ? 0 : pidx + 1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int d0;
        int h0;
        tv[0] = '{f_nb: 1'b0, f_blk: 1'b0, tog: 1'b0, n_chk: 10, e_blk: 1'b0, e_nb: 1'b0, e_err: 10 - 10, e_chk: 10};
        tv[1] = '{f_nb: 1'b1, f_blk: 1'b0, tog: 1'b1, n_chk: 8,  e_blk: 1'b0, e_nb: 1'b1, e_err: 8,  e_chk: 8};
        tv[2] = '{f_nb: 1'b0, f_blk: 1'b1, tog: 1'b0, n_chk: 12, e_blk: 1'b1, e_nb: 1'b0, e_err: 12, e_chk: 12};

        #12;
        check("reset_busy", int'(d_busy), 0);
        check("reset_done", int'(d_done), 0);
        check("reset_err_cnt", int'(d_err_cnt), 0);
        check("reset_chk_cnt", int'(d_chk_cnt), 0);
        rst_n = 1'b1;
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("idle_stop_busy", int'(d_busy), 0);
        check("idle_stop_done", int'(d_done), 0);

        for (int r = 0; r < 3; r++) begin
            fault_nb  = tv[r].f_nb;
            fault_blk = tv[r].f_blk;
            a_tog     = tv[r].tog;
            step();
            step();
            d0 = n_done_d;
            pulse_start();
            check($sformatf("v%0d_busy_start", r), int'(d_busy), 1);
            repeat (FILL - 1) step();
            check($sformatf("v%0d_chk_pre", r), int'(d_chk_cnt), 0);
            for (int k = 1; k <= tv[r].n_chk; k++) begin
                if (k == tv[r].n_chk) stop = 1'b1;
                step();
                stop = 1'b0;
            end
            check($sformatf("v%0d_err_blk", r), int'(d_err_blk), int'(tv[r].e_blk));
            check($sformatf("v%0d_err_nb", r), int'(d_err_nb), int'(tv[r].e_nb));
            check($sformatf("v%0d_err_cnt", r), int'(d_err_cnt), tv[r].e_err);
            check($sformatf("v%0d_chk_cnt", r), int'(d_chk_cnt), tv[r].e_chk);
            check($sformatf("v%0d_done", r), int'(d_done), 1);
            check($sformatf("v%0d_busy_end", r), int'(d_busy), 0);
            step();
            check($sformatf("v%0d_done_low", r), int'(d_done), 0);
            check($sformatf("v%0d_done_pulses", r), n_done_d - d0, 1);
        end

        check("sat_err_blk", int'(s_err_blk), 1);
        check("sat_err_cnt", int'(s_err_cnt), 7);
        check("sat_chk_cnt", int'(s_chk_cnt), 7);
        fault_blk = 1'b0;
        a_tog     = 1'b0;

        step();
        step();
        h0 = n_done_h;
        pulse_start();
        check("halt_busy_start", int'(h_busy), 1);
        repeat (FILL - 1) step();
        step();
        step();
        inj = 1'b1;
        step();
        inj = 1'b0;
        check("halt_busy", int'(h_busy), 0);
        check("halt_done", int'(h_done), 1);
        check("halt_chk_cnt", int'(h_chk_cnt), 3);
        check("halt_err_cnt", int'(h_err_cnt), 1);
        check("halt_err_blk", int'(h_err_blk), 1);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        check("halt_frozen_chk", int'(h_chk_cnt), 3);
        check("halt_frozen_busy", int'(h_busy), 0);
        check("halt_done_pulses", n_done_h - h0, 1);
        pulse_start();
        check("halt_restart_busy", int'(h_busy), 1);
        check("halt_restart_chk", int'(h_chk_cnt), 0);
        check("halt_restart_err", int'(h_err_cnt), 0);
        check("halt_restart_blk", int'(h_err_blk), 0);

        fault_blk = 1'b1;
        pulse_start();
        repeat (FILL - 1) step();
        repeat (4) step();
        check("ss_pre_err_cnt", int'(d_err_cnt), 4);
        fault_blk = 1'b0;
        d0 = n_done_d;
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_err_cnt", int'(d_err_cnt), 0);
        check("ss_chk_cnt", int'(d_chk_cnt), 0);
        check("ss_busy", int'(d_busy), 1);
        check("ss_done", int'(d_done), 0);
        repeat (FILL - 1) step();
        check("ss_chk_fill", int'(d_chk_cnt), 0);
        step();
        check("ss_chk_first", int'(d_chk_cnt), 1);
        check("ss_no_done", n_done_d - d0, 0);

        fault_blk = 1'b1;
        pulse_start();
        repeat (FILL - 1) step();
        repeat (5) step();
        check("rst_pre_err_cnt", int'(d_err_cnt), 5);
        #3 rst_n = 1'b0;
        #1;
        check("rst_busy", int'(d_busy), 0);
        check("rst_done", int'(d_done), 0);
        check("rst_err_blk", int'(d_err_blk), 0);
        check("rst_err_cnt", int'(d_err_cnt), 0);
        check("rst_chk_cnt", int'(d_chk_cnt), 0);
        #2 rst_n = 1'b1;
        fault_blk = 1'b0;
        step();
        step();
        check("rst_idle_busy", int'(d_busy), 0);
        check("rst_idle_chk", int'(d_chk_cnt), 0);
        pulse_start();
        check("rst_resume_busy", int'(d_busy), 1);
        repeat (FILL) step();
        check("rst_resume_chk", int'(d_chk_cnt), 1);
        check("rst_resume_err", int'(d_err_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_delay_checker.md
# pipe_delay_checker

Downstream checker for the blocked/non-blocked assignment demo stage. It consumes that stage's four outputs together with the same stimulus `a`, and keeps its own 2-deep delay model of `a`. Every checked cycle it verifies two rules: the non-blocked pair behaves as a 2-stage shift chain, and the blocked pair collapses to a single stage. It reports sticky error flags, a saturating mismatch count and a checked-cycle count, under a small start/stop FSM.

## Interface
Parameters:
- `CNT_W`, default 8: width of `err_cnt` and `chk_cnt`.
- `FILL`, default 2: edges after `start` before the first comparison. Legal range is ≥2.
- `HALT_ON_ERR`, default 0: when 1, the first mismatch stops checking (enters HALT).

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: synchronous pulse. Clears results and begins a run.
- `stop`  in  1: synchronous pulse. Ends a run.
- `a`  in  1: the stimulus bit driven to the upstream stage.
- `b_blocked`, `c_blocked`  in  1 each: upstream blocked-chain outputs.
- `b_non_blocked`, `c_non_blocked`  in  1 each: upstream non-blocked-chain outputs.
- `busy`  out  1: high in FILL or CHECK.
- `done`  out  1: one-cycle pulse when a run ends.
- `err_blk`  out  1: sticky blocked-chain mismatch.
- `err_nb`  out  1: sticky non-blocked-chain mismatch.
- `err_cnt`  out  CNT_W: edges with any mismatch, saturating.
- `chk_cnt`  out  CNT_W: edges compared, saturating.

## Operation
Delay model:
- `a_d1 <= a` and `a_d2 <= a_d1` on every edge, in every state.
- Both registers reset to 0.

Mismatch terms, evaluated at an edge using the pre-edge register values:
- `mis_nb = (b_non_blocked != a_d1) | (c_non_blocked != a_d2)`.
- `mis_blk = (b_blocked != a_d1) | (c_blocked != a_d1)`.

States are IDLE, FILL, CHECK and HALT. Reset state is IDLE.

- **IDLE**
  - `start` → FILL. Clear `fill_cnt`, `err_blk`, `err_nb`, `err_cnt` and `chk_cnt`.
  - `stop` alone is ignored.
- **FILL**
  - Increment `fill_cnt` each edge.
  - When the count reaches `FILL-1`, go to CHECK. The first comparison therefore happens at the `FILL`-th edge after the start edge.
  - `start` restarts FILL and clears everything.
  - `stop` → IDLE with `done` pulsed, no comparisons made.
- **CHECK**, at every edge:
  - Compare, and increment `chk_cnt` (saturating).
  - Set `err_blk` on `mis_blk`; set `err_nb` on `mis_nb`.
  - Increment `err_cnt` by 1 if `mis_blk | mis_nb` (saturating at 2^CNT_W−1).
  - If a mismatch occurs and `HALT_ON_ERR=1`: go to HALT and pulse `done`.
  - Else if `stop`: this edge is still compared; go to IDLE and pulse `done`.
- **HALT**
  - Results are frozen.
  - `start` → FILL with a full clear. `stop` is ignored.

Simultaneous events:
- `start` and `stop` on the same edge: `start` wins (restart). No `done` is pulsed.
- Mismatch and `stop` on the same edge with `HALT_ON_ERR=1`: go to HALT. Exactly one `done` pulse.

Reset:
- Asserting `rst_n` mid-run immediately forces IDLE.
- All outputs and internal registers go to 0. No `done` is pulsed.

## Timing
- All outputs are registered. Their reset value is 0.
- Flags and counters reflect comparison results starting from the edge that performed the comparison.
- `busy` rises the cycle after the `start` edge. It falls the cycle after the terminating edge.
- `done` is high for exactly the one cycle after the terminating edge.
- Latency from `start` to the first result: `FILL` edges.
- Ports `start`, `stop` and `a` are sampled only on rising edges. `rst_n` is not synchronised inside this block.

## Test plan
1. **Clean run**
   - Stimulus: real upstream stage, `a` = 1,0,1,1,0,0,1,0,1,1 repeating; `start`, then `stop` at the 10th CHECK edge.
   - Required: `err_cnt`=0, `chk_cnt`=10, `err_blk`=`err_nb`=0, a single one-cycle `done`.
2. **Non-blocked fault**
   - Stimulus: `c_non_blocked` tied to `b_non_blocked`, `a` toggling every cycle, 8 check edges.
   - Required: `err_nb`=1, `err_blk`=0, `err_cnt`=8, `chk_cnt`=8.
3. **Blocked fault and saturation**
   - Stimulus: `CNT_W`=3, `c_blocked` inverted, 12 check edges.
   - Required: `err_blk`=1, `err_cnt`=7 held, `chk_cnt`=7 held.
4. **Halt on error**
   - Stimulus: `HALT_ON_ERR`=1, single injected mismatch at the 3rd check edge.
   - Required: HALT state, `chk_cnt`=3, `err_cnt`=1, `busy`=0, one `done`. A following `start` clears all results and returns `busy`=1.
5. **Simultaneous start and stop**
   - Stimulus: `start` and `stop` asserted together in CHECK with `err_cnt`=4.
   - Required: counters cleared, state FILL, no `done`, first comparison `FILL` edges later.
6. **Async reset mid-run**
   - Stimulus: `rst_n` pulled low between edges during CHECK with `err_cnt`=5.
   - Required: all outputs 0 before the next edge, IDLE after release, `start` is still needed to resume.
